// File: rtl/seq_addsub_disp_pkg.sv
// Shared types and constants for the sequential add/subtract unit with a 7-segment readout.
// Segment patterns are active-low, with bit 0 = segment a and bit 6 = segment g.
package seq_addsub_disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

   // Decimal digit count of 2^(width+1), i.e. the digits needed for any result magnitude
   function automatic int min_digits(input int width);
      int v;
      int d;
      v = 1 << (width + 1);
      d = 0;
      for (int k = 0; k < 10; k++) begin
         if (v > 0) begin
            d++;
            v = v / 10;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/seq_addsub_disp_seg7.sv
// BCD digit to active-low 7-segment pattern; a blank request or a non-decimal code shows nothing.
module seg7_decode
   import seq_addsub_disp_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seq_addsub_disp.sv
// Unsigned add/subtract whose magnitude is converted to BCD by a bit-serial double-dabble
// and shown on DIGITS active-low 7-segment digits plus a sign digit.
module seq_addsub_disp
   import seq_addsub_disp_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  sub,
   input  logic [WIDTH-1:0]      op_a,
   input  logic [WIDTH-1:0]      op_b,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH:0]        result,
   output logic                  neg,
   output logic [7*DIGITS-1:0]   seg,
   output logic [6:0]            seg_sign
);

   localparam int CW = $clog2(WIDTH + 2);

   if (WIDTH < 4 || WIDTH > 16) begin : g_width_check
      $error("seq_addsub_disp: WIDTH must lie in 4..16");
   end
   if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
      $error("seq_addsub_disp: DIGITS too small to show every result of WIDTH-bit operands");
   end

   state_t                state;
   logic [CW-1:0]         bit_cnt;
   logic [WIDTH:0]        mag;
   logic [WIDTH:0]        mag_val;
   logic                  neg_pend;
   logic [4*DIGITS-1:0]   bcd;
   logic [4*DIGITS-1:0]   bcd_fix;
   logic [4*DIGITS-1:0]   bcd_next;
   logic [4*DIGITS-1:0]   disp_bcd;
   logic [WIDTH:0]        mag_in;
   logic                  neg_in;
   logic [DIGITS-1:0]     blank_vec;
   logic                  nz_seen;

   always_comb begin
      mag_in = {1'b0, op_a} + {1'b0, op_b};
      neg_in = 1'b0;
      if (sub) begin
         if (op_a >= op_b) begin
            mag_in = {1'b0, op_a} - {1'b0, op_b};
         end else begin
            mag_in = {1'b0, op_b} - {1'b0, op_a};
            neg_in = 1'b1;
         end
      end
   end

   always_comb begin
      bcd_fix = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_fix[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      bcd_next = {bcd_fix[4*DIGITS-2:0], mag[WIDTH]};
   end

   // done is raised on the DONE->IDLE edge so a start held high is re-accepted right after it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         mag      <= '0;
         mag_val  <= '0;
         neg_pend <= 1'b0;
         bcd      <= '0;
         disp_bcd <= '0;
         result   <= '0;
         neg      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mag      <= mag_in;
                  mag_val  <= mag_in;
                  neg_pend <= neg_in;
                  bcd      <= '0;
                  bit_cnt  <= CW'(WIDTH + 1);
                  busy     <= 1'b1;
                  state    <= ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               bcd     <= bcd_next;
               mag     <= mag << 1;
               bit_cnt <= bit_cnt - 1'b1;
               if (bit_cnt == CW'(1)) begin
                  disp_bcd <= bcd_next;
                  result   <= mag_val;
                  neg      <= neg_pend;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A digit is blanked when it and every digit above it are zero; the units digit never blanks
   always_comb begin
      blank_vec = '0;
      nz_seen   = 1'b0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (disp_bcd[4*i +: 4] != 4'd0) nz_seen = 1'b1;
         blank_vec[i] = ~nz_seen;
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      seg7_decode u_seg7 (
         .bcd   (disp_bcd[4*g +: 4]),
         .blank (blank_vec[g]),
         .seg   (seg[7*g +: 7])
      );
   end

   assign seg_sign = neg ? SEG_MINUS : SEG_BLANK;

endmodule

// File: tb/tb_seq_addsub_disp.sv
// Bench for seq_addsub_disp (WIDTH=8, DIGITS=3): directed and random operations compared
// against an arithmetic reference of value, sign, decimal digits and segment patterns.
module tb_seq_addsub_disp;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;
   localparam int LAT    = WIDTH + 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic                sub;
   logic [WIDTH-1:0]    op_a;
   logic [WIDTH-1:0]    op_b;
   logic                busy;
   logic                done;
   logic [WIDTH:0]      result;
   logic                neg;
   logic [7*DIGITS-1:0] seg;
   logic [6:0]          seg_sign;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int accept_cyc;
   int exp_a;
   int exp_b;
   bit exp_sub;

   seq_addsub_disp #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .sub      (sub),
      .op_a     (op_a),
      .op_b     (op_b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .neg      (neg),
      .seg      (seg),
      .seg_sign (seg_sign)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] digit_seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic void ref_model(input int a, input int b, input bit s,
                                     output int mag, output bit n);
      n = 1'b0;
      if (!s) mag = a + b;
      else if (a >= b) mag = a - b;
      else begin
         mag = b - a;
         n   = 1'b1;
      end
   endfunction

   function automatic logic [7*DIGITS-1:0] ref_seg(input int mag);
      logic [7*DIGITS-1:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (i > 0 && mag < p) r[7*i +: 7] = 7'b1111111;
         else                  r[7*i +: 7] = digit_seg((mag / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   task automatic checkReset(input string tag);
      check({tag, "_busy"},     32'(busy),     32'd0);
      check({tag, "_done"},     32'(done),     32'd0);
      check({tag, "_result"},   32'(result),   32'd0);
      check({tag, "_neg"},      32'(neg),      32'd0);
      check({tag, "_seg_sign"}, 32'(seg_sign), 32'h7f);
      check({tag, "_seg"},      32'(seg),      32'({7'b1111111, 7'b1111111, 7'b1000000}));
   endtask

   // Called on a falling edge; the next rising edge accepts the operation
   task automatic applyStimulus(input int a, input int b, input bit s);
      op_a    = WIDTH'(a);
      op_b    = WIDTH'(b);
      sub     = s;
      start   = 1'b1;
      exp_a   = a;
      exp_b   = b;
      exp_sub = s;
      @(negedge clk);
      accept_cyc = cyc;
      start      = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
   endtask

   task automatic checkOutput(input string tag);
      int m;
      bit n;
      int waited;
      ref_model(exp_a, exp_b, exp_sub, m, n);
      waited = 0;
      while (!done && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      check({tag, "_latency"},   32'(cyc - accept_cyc), 32'(LAT));
      check({tag, "_result"},    32'(result), 32'(m));
      check({tag, "_neg"},       32'(neg), 32'(n));
      check({tag, "_seg"},       32'(seg), 32'(ref_seg(m)));
      check({tag, "_seg_sign"},  32'(seg_sign), n ? 32'h3f : 32'h7f);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      check({tag, "_done_single"}, 32'(done), 32'd0);
   endtask

   initial begin
      int ra [48];
      int rb [48];
      bit rs [48];
      int last_done;
      int done_cnt;
      int m;
      bit n;

      rst_n = 1'b0;
      start = 1'b0;
      sub   = 1'b0;
      op_a  = '0;
      op_b  = '0;
      repeat (3) @(negedge clk);
      checkReset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(200, 100, 1'b0);
      checkOutput("add_200_100");
      check("add_200_100_digits", 32'(seg),
            32'({7'b0110000, 7'b1000000, 7'b1000000}));

      applyStimulus(5, 9, 1'b1);
      checkOutput("sub_5_9");
      check("sub_5_9_digits", 32'(seg), 32'({7'b1111111, 7'b1111111, 7'b0011001}));

      applyStimulus(0, 0, 1'b1);
      checkOutput("sub_0_0");

      applyStimulus(255, 255, 1'b0);
      checkOutput("add_255_255");
      repeat (5) @(negedge clk);
      check("hold_result", 32'(result), 32'd510);
      check("hold_seg", 32'(seg), 32'(ref_seg(510)));

      for (int k = 0; k < 8; k++) begin
         applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       bit'($urandom_range(0, 1)));
         checkOutput("random");
      end

      // Operands and start disturbed while busy must not affect the captured operation
      applyStimulus(17, 200, 1'b1);
      repeat (3) begin
         op_a  = WIDTH'($urandom);
         op_b  = WIDTH'($urandom);
         sub   = 1'b0;
         start = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("busy_ignore");

      // start held high with fresh operands every cycle
      last_done = -1;
      done_cnt  = 0;
      for (int c = 0; c < 48; c++) begin
         ra[c] = int'($urandom_range(0, 255));
         rb[c] = int'($urandom_range(0, 255));
         rs[c] = bit'($urandom_range(0, 1));
         op_a  = WIDTH'(ra[c]);
         op_b  = WIDTH'(rb[c]);
         sub   = rs[c];
         start = 1'b1;
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (last_done < 0) check("b2b_first_done", 32'(c), 32'(LAT));
            else               check("b2b_period", 32'(c - last_done), 32'(LAT + 1));
            last_done = c;
            if (c >= LAT) begin
               ref_model(ra[c-LAT], rb[c-LAT], rs[c-LAT], m, n);
               check("b2b_result", 32'(result), 32'(m));
               check("b2b_neg",    32'(neg), 32'(n));
               check("b2b_seg",    32'(seg), 32'(ref_seg(m)));
            end
         end
      end
      start = 1'b0;
      check("b2b_done_count", 32'(done_cnt), 32'd4);
      repeat (15) @(negedge clk);

      // Reset asserted ahead of edge t+5 aborts the conversion
      applyStimulus(123, 45, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkReset("abort");
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      done_cnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_result_kept_reset", 32'(result), 32'd0);
      applyStimulus(99, 1, 1'b1);
      checkOutput("after_abort");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
